ctrl_seq: RTL and testbench

Multi-cycle instruction sequencer that drives the program counter's `incPC`, `loadPC` and `altPC` inputs. It latches the 8-bit word returned by instruction memory at the PC's 4-bit `ins_mem` address. It decodes the word into ALU and register-file strobes and resolves jumps. It sits directly upstream of the program counter and downstream of instruction memory. It is the only source of PC updates, including PC initialisation after reset.

---
 rtl/ctrl_pkg.sv | 54 +++++
 rtl/ctrl_decode.sv | 79 +++++++
 rtl/ctrl_seq.sv | 125 ++++++++++++
 tb/tb_ctrl_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared definitions for the ctrl_seq instruction sequencer.
//
// Contents:
//   - 4-bit opcode constants (upper nibble of the instruction word)
//   - 3-bit FSM state encoding
//   - 3-bit ALU operation encodings
//   - dec_t: decoded control bundle passed from ctrl_decode to ctrl_seq
//   - zext4: zero-extend a 4-bit operand to 8 bits
package ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_JNZ  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4
    } alu_op_t;

    // Decoded control for one instruction. inc and load are mutually
    // exclusive by construction in ctrl_decode.
    typedef struct packed {
        logic       inc;
        logic       load;
        logic [3:0] target;
        logic       reg_we;
        alu_op_t    alu_op;
        logic       halt;
        logic       illegal;
    } dec_t;

    function automatic logic [7:0] zext4(input logic [3:0] v);
        return {4'h0, v};
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode -- combinational instruction decode for ctrl_seq.
//
// Ports:
//   ir        in  8  instruction register ([7:4] opcode, [3:0] operand)
//   zero_flag in  1  ALU zero flag used by the conditional jumps
//   dec       out    dec_t bundle: PC strobes, jump target, reg_we,
//                    alu_op, halt request, illegal-opcode trap
//
// Build option: CTRL_ILLEGAL_TRAP_EN
//   defined   -> opcodes 9..E request a halt with the illegal bit set and
//                assert no PC strobe, so the PC stays on the bad opcode
//   undefined -> opcodes 9..E behave as NOP and illegal is never raised
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [7:0] ir,
    input  logic       zero_flag,
    output dec_t       dec
);

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_PASS;
        dec.target = ir[3:0];
        case (ir[7:4])
            OP_NOP: dec.inc = 1'b1;
            OP_LDI: begin
                dec.reg_we = 1'b1;
                dec.alu_op = ALU_PASS;
                dec.inc    = 1'b1;
            end
            OP_ADD: begin
                dec.reg_we = 1'b1;
                dec.alu_op = ALU_ADD;
                dec.inc    = 1'b1;
            end
            OP_SUB: begin
                dec.reg_we = 1'b1;
                dec.alu_op = ALU_SUB;
                dec.inc    = 1'b1;
            end
            OP_AND: begin
                dec.reg_we = 1'b1;
                dec.alu_op = ALU_AND;
                dec.inc    = 1'b1;
            end
            OP_OR: begin
                dec.reg_we = 1'b1;
                dec.alu_op = ALU_OR;
                dec.inc    = 1'b1;
            end
            OP_JMP: dec.load = 1'b1;
            OP_JZ: begin
                dec.load = zero_flag;
                dec.inc  = ~zero_flag;
            end
            OP_JNZ: begin
                dec.load = ~zero_flag;
                dec.inc  = zero_flag;
            end
            OP_HALT: begin
                // Step past the HALT so a resume continues with the next word.
                dec.inc  = 1'b1;
                dec.halt = 1'b1;
            end
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                // No strobe: the PC stays on the offending word, so a resume
                // re-executes it and traps again.
                dec.halt    = 1'b1;
                dec.illegal = 1'b1;
`else
                dec.inc = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq -- three-cycle (FETCH/DECODE/EXEC) instruction sequencer that
// owns every update of the downstream, reset-less program counter.
//
// Ports:
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   instr     in   8  instruction memory word at the current PC
//   zero_flag in   1  ALU zero flag, sampled at the end of DECODE
//   run       in   1  start from IDLE / resume from HALT (level)
//   incPC     out  1  PC increment strobe (one EXEC cycle)
//   loadPC    out  1  PC load strobe (EXEC of a taken jump, and IDLE)
//   altPC     out  8  PC load value
//   ir        out  8  instruction register
//   alu_op    out  3  ALU operation select
//   imm       out  8  zero-extended operand
//   reg_we    out  1  accumulator write enable (one EXEC cycle)
//   halted    out  1  high while in HALT
//   illegal   out  1  sticky illegal-opcode flag
//
// Build option: CTRL_ILLEGAL_TRAP_EN (see ctrl_decode). When undefined the
// decoder never flags an illegal opcode, so illegal stays 0.
//
// All outputs are registered. Strobes are computed in DECODE and present
// for the whole EXEC cycle, so the PC moves on EXEC's closing edge and the
// following FETCH already sees the new address.
module ctrl_seq
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] instr,
    input  logic       zero_flag,
    input  logic       run,
    output logic       incPC,
    output logic       loadPC,
    output logic [7:0] altPC,
    output logic [7:0] ir,
    output logic [2:0] alu_op,
    output logic [7:0] imm,
    output logic       reg_we,
    output logic       halted,
    output logic       illegal
);

    state_t state_reg;
    logic   halt_pend_reg;
    logic   trap_pend_reg;
    dec_t   dec;

    ctrl_decode u_decode (
        .ir        (ir),
        .zero_flag (zero_flag),
        .dec       (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            ir            <= 8'h00;
            incPC         <= 1'b0;
            loadPC        <= 1'b0;
            altPC         <= 8'h00;
            alu_op        <= ALU_PASS;
            imm           <= 8'h00;
            reg_we        <= 1'b0;
            halted        <= 1'b0;
            illegal       <= 1'b0;
            halt_pend_reg <= 1'b0;
            trap_pend_reg <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state below re-asserts them.
            incPC  <= 1'b0;
            loadPC <= 1'b0;
            reg_we <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    altPC <= 8'h00;
                    // Leave only once loadPC is already high, so the PC is
                    // guaranteed to take 0 on this same edge even when run
                    // was high straight out of reset.
                    if (run && loadPC) begin
                        state_reg <= ST_FETCH;
                    end else begin
                        loadPC <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    ir        <= instr;
                    state_reg <= ST_DECODE;
                end
                ST_DECODE: begin
                    alu_op        <= dec.alu_op;
                    imm           <= zext4(ir[3:0]);
                    reg_we        <= dec.reg_we;
                    incPC         <= dec.inc;
                    loadPC        <= dec.load;
                    altPC         <= dec.load ? zext4(dec.target) : 8'h00;
                    halt_pend_reg <= dec.halt;
                    trap_pend_reg <= dec.illegal;
                    state_reg     <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (halt_pend_reg) begin
                        state_reg <= ST_HALT;
                        halted    <= 1'b1;
                        if (trap_pend_reg) begin
                            illegal <= 1'b1;
                        end
                    end else begin
                        state_reg <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (run) begin
                        halted    <= 1'b0;
                        state_reg <= ST_FETCH;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq -- self-checking bench for ctrl_seq.
// A behavioural PC plus 16-word instruction memory sit around the DUT; an
// instruction-level model tracks the expected PC and sticky illegal flag and
// derives the expected EXEC strobes from the opcode table.
`timescale 1ns/1ps
module tb_ctrl_seq;
    import ctrl_pkg::*;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] instr;
    logic       zero_flag = 1'b0;
    logic       run = 1'b0;
    logic       incPC, loadPC, reg_we, halted, illegal;
    logic [7:0] altPC, ir, imm;
    logic [2:0] alu_op;

    logic [7:0] mem [16];
    logic [3:0] pc_env;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    logic [3:0] m_pc;
    bit         m_illegal;

    always #5 clk = ~clk;

    ctrl_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .zero_flag (zero_flag),
        .run       (run),
        .incPC     (incPC),
        .loadPC    (loadPC),
        .altPC     (altPC),
        .ir        (ir),
        .alu_op    (alu_op),
        .imm       (imm),
        .reg_we    (reg_we),
        .halted    (halted),
        .illegal   (illegal)
    );

    // Reset-less program counter driven only by the sequencer strobes.
    always @(posedge clk) begin
        if (loadPC)     pc_env <= altPC[3:0];
        else if (incPC) pc_env <= pc_env + 4'd1;
    end
    assign instr = mem[pc_env];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) chk("inv_inc_and_load", 32'(incPC & loadPC), 32'd0);
    end

    function automatic logic [2:0] exp_alu(input logic [3:0] op);
        case (op)
            4'h1:    return ALU_PASS;
            4'h2:    return ALU_ADD;
            4'h3:    return ALU_SUB;
            4'h4:    return ALU_AND;
            default: return ALU_OR;
        endcase
    endfunction

    // Reset, check cleared outputs, start from IDLE. Returns at the
    // negedge inside the first FETCH cycle.
    task automatic start_run();
        rst_n = 1'b0;
        run = 1'b0;
        zero_flag = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_incPC", 32'(incPC), 32'h0);
        chk("rst_loadPC", 32'(loadPC), 32'h0);
        chk("rst_altPC", 32'(altPC), 32'h0);
        chk("rst_alu_op", 32'(alu_op), 32'h0);
        chk("rst_imm", 32'(imm), 32'h0);
        chk("rst_reg_we", 32'(reg_we), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;
        @(negedge clk);
        chk("idle_loadPC", 32'(loadPC), 32'h1);
        chk("idle_altPC", 32'(altPC), 32'h0);
        chk("idle_incPC", 32'(incPC), 32'h0);
        @(negedge clk);
        chk("fetch_loadPC", 32'(loadPC), 32'h0);
        m_pc = 4'h0;
        m_illegal = 1'b0;
    endtask

    // One instruction, entered and left at a FETCH-cycle negedge.
    // zf_sel < 0 picks a random zero_flag; halt_wait > 0 holds run low for
    // that many HALT cycles, otherwise the resume time is random.
    task automatic do_instr(input int zf_sel, input int halt_wait);
        logic [7:0] word;
        logic [3:0] op, opr;
        bit zf, jmp, alu, trap, halt, r;
        word = mem[m_pc];
        op   = word[7:4];
        opr  = word[3:0];
        chk("fetch_pc", 32'(pc_env), 32'(m_pc));
        zf = (zf_sel < 0) ? bit'($urandom_range(0, 1)) : zf_sel[0];
        zero_flag = zf;
        run = bit'($urandom_range(0, 1));
        @(negedge clk);
        chk("decode_quiet", 32'({incPC, loadPC, reg_we}), 32'h0);
        run = bit'($urandom_range(0, 1));
        @(negedge clk);
        jmp  = (op == 4'h6) || (op == 4'h7 && zf) || (op == 4'h8 && !zf);
        alu  = (op >= 4'h1) && (op <= 4'h5);
        trap = TRAP_EN && (op >= 4'h9) && (op <= 4'hE);
        halt = (op == 4'hF) || trap;
        $display("instr pc=%0h word=%02h zf=%0d inc=%0d load=%0d alt=%02h we=%0d alu=%0d imm=%02h",
                 m_pc, word, zf, incPC, loadPC, altPC, reg_we, alu_op, imm);
        chk("exec_ir", 32'(ir), 32'(word));
        chk("exec_incPC", 32'(incPC), 32'(!jmp && !trap));
        chk("exec_loadPC", 32'(loadPC), 32'(jmp));
        chk("exec_reg_we", 32'(reg_we), 32'(alu));
        chk("exec_halted", 32'(halted), 32'h0);
        chk("exec_illegal", 32'(illegal), 32'(m_illegal));
        if (jmp) chk("exec_altPC", 32'(altPC), 32'({4'h0, opr}));
        if (alu) begin
            chk("exec_alu_op", 32'(alu_op), 32'(exp_alu(op)));
            chk("exec_imm", 32'(imm), 32'({4'h0, opr}));
        end
        if (jmp)       m_pc = opr;
        else if (!trap) m_pc = m_pc + 4'd1;
        if (halt) begin
            m_illegal = m_illegal | trap;
            run = 1'b0;
            @(negedge clk);
            chk("halt_halted", 32'(halted), 32'h1);
            chk("halt_quiet", 32'({incPC, loadPC, reg_we}), 32'h0);
            chk("halt_illegal", 32'(illegal), 32'(m_illegal));
            for (int i = 0; ; i++) begin
                if (halt_wait > 0) r = (i >= halt_wait);
                else               r = (i >= 20) || ($urandom_range(0, 3) == 0);
                run = r;
                @(negedge clk);
                if (r) break;
                chk("halt_hold", 32'({halted, incPC, loadPC, reg_we}), 32'h8);
            end
            chk("resume_halted", 32'(halted), 32'h0);
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // NOP at address 0
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        start_run();
        do_instr(-1, 0);
        do_instr(-1, 0);

        // LDI 5; ADD 3
        mem[0] = 8'h15;
        mem[1] = 8'h23;
        start_run();
        do_instr(-1, 0);
        do_instr(-1, 0);

        // JMP A; JZ 2 taken; JZ 9 not taken
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0]  = 8'h6A;
        mem[10] = 8'h72;
        mem[2]  = 8'h79;
        start_run();
        do_instr(-1, 0);
        do_instr(1, 0);
        do_instr(0, 0);
        do_instr(-1, 0);

        // HALT at 7, held 10 cycles, resume at 8
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[7] = 8'hF0;
        mem[8] = 8'h14;
        start_run();
        for (int i = 0; i < 7; i++) do_instr(-1, 0);
        do_instr(-1, 10);
        do_instr(-1, 0);

        // Opcode B: trap (re-traps on resume) or NOP
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'hB3;
        start_run();
        do_instr(-1, 2);
        do_instr(-1, 1);

        // Reset during EXEC of JMP: strobe lost, PC re-zeroed
        mem[0] = 8'h00;
        mem[1] = 8'h65;
        start_run();
        do_instr(-1, 0);
        @(negedge clk);
        @(negedge clk);
        chk("jmp_exec_loadPC", 32'(loadPC), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_loadPC", 32'(loadPC), 32'h0);
        chk("rst_mid_incPC", 32'(incPC), 32'h0);
        start_run();
        do_instr(-1, 0);

        // Random programs over all opcodes
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            start_run();
            for (int k = 0; k < 40; k++) do_instr(-1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
